pipelined_shifter: RTL
======================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the 16-bit combinational shifter.
- Supports SLL, SRA, ROR and SRL on a WIDTH-bit operand.
- Decomposed into log2(WIDTH) registered barrel stages with a valid/ready handshake on both sides.
- Sits between the ALU operand mux and the writeback mux, so shifts no longer limit cycle time.

Parameters:
- WIDTH, 16: operand width; power of two, minimum 4.
- SHW, $clog2(WIDTH): shift-amount width; derived, do not override.
- STAGES, SHW: pipeline depth; one register per shift-amount bit; derived.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand and command present
- in_ready  out  1  block accepts input this cycle
- in_data  in  WIDTH  value to shift
- in_amt  in  SHW  shift amount, unsigned
- in_mode  in  2  00=SLL, 01=SRA, 10=ROR, 11=SRL
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result

Behaviour:
- Reset: clk is the single clock; rst is synchronous and active-high.
  - On the clk edge with rst=1, all stage valid bits, data, amount and mode registers clear to 0.
  - After reset: out_valid=0, out_data=0, in_ready=1.
  - Reset mid-operation discards every in-flight item; no partial result is ever presented.
- Stage k (k=0..STAGES-1) processes bit k of the amount:
  - If amt[k]=1: applies a shift of 2^k per mode. Otherwise passes data unchanged.
  - Forwards the remaining amount bits and the mode to the next stage.
- Mode rules per stage:
  - SLL: zero-fill at LSB.
  - SRL: zero-fill at MSB.
  - SRA: fill with the current MSB. Sign is preserved because each stage re-reads the MSB of its own input.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Amount 0 passes data unchanged in every mode.
- Maximum amount is WIDTH-1. There is no amount >= WIDTH case.
- Latency: a transfer on the input at edge N appears on out_data/out_valid after edge N+STAGES, provided no stall occurs.
  - Throughput is one result per cycle.
- Stall:
  - stall = out_valid & ~out_ready.
  - While stall=1, every stage register holds its value and in_ready=0.
  - in_ready = ~stall, purely combinational from out_valid and out_ready.
- Input transfer occurs when in_valid & in_ready. Otherwise stage 0 loads a bubble (valid=0).
- Bubbles are not collapsed. Any bubble advances whenever stall=0.
- Output transfer occurs when out_valid & out_ready. The next item or bubble loads on the same edge.
- While out_valid=1, out_data is held stable until the output transfer completes.
- in_mode and in_amt are sampled only on an input transfer. Values present on cycles without in_valid are ignored.
- Simultaneous input and output transfers in the same cycle are legal. The pipeline advances by one position.

Optional Feature:
- Macro: SHIFTER_FLAGS_EN.
- When defined, the block adds two outputs, both registered alongside out_data and reset to 0:
  - out_z (1 bit): high when out_data equals 0.
  - out_n (1 bit): equals out_data[WIDTH-1].
  - Both are computed in the final stage, which adds no latency.
- When undefined, neither port exists and the data path is unchanged.

Decomposition:
- Package shifter_pkg:
  - typedef enum logic[1:0] shift_mode_t {SH_SLL=2'b00, SH_SRA=2'b01, SH_ROR=2'b10, SH_SRL=2'b11}.
  - Localparam MIN_WIDTH=4.
- Sub-module shifter_stage, parametrised by WIDTH and stage index K:
  - Contains the combinational 2^K shift plus valid/data/amt/mode registers with hold-on-stall.
  - The top level instantiates it STAGES times with a generate loop.

Test Plan (WIDTH=16, so latency is 4 cycles):
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0x0000, in_ready=1 throughout.
- Directed modes, back-to-back one per cycle, out_ready=1:
  - SLL 0x8001 by 1 -> 0x0002
  - SRA 0x8000 by 15 -> 0xFFFF
  - ROR 0x0001 by 4 -> 0x1000
  - SRL 0x8000 by 15 -> 0x0001
  - Results must appear on 4 consecutive cycles, starting 4 edges after the first input.
- Zero amount: 0xA5A5 by 0 in all four modes -> 0xA5A5 each time.
- Backpressure:
  - Stream 6 ops, each SLL 0x0001 by amt=i; drop out_ready for 3 cycles once the first result is valid.
  - Required: out_data holds 0x0001 and in_ready=0 during the stall.
  - Results 0x0001, 0x0002, 0x0004, 0x0008, 0x0010, 0x0020 appear in order with none lost or duplicated.
- Reset mid-flight:
  - Issue 3 ops, assert rst for one cycle after the 2nd edge.
  - Required: no out_valid for any of the 3 ops; a fresh op after reset returns with normal 4-cycle latency.
- Randomised reference check: 1000 random data/amt/mode with random out_ready, compared against these models:
  - SLL: data << amt
  - SRA: $signed(data) >>> amt
  - SRL: data >> amt
  - ROR: low 16 bits of {data,data} >> amt
  - Zero mismatches allowed; with SHIFTER_FLAGS_EN defined, out_z and out_n are also checked.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined shifter: shift-mode encoding and width limits.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRA = 2'b01,
    SH_ROR = 2'b10,
    SH_SRL = 2'b11
  } shift_mode_t;

  localparam int MIN_WIDTH = 4;

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter pipeline stage: conditionally shifts by 2^K, then registers
// data, remaining amount and mode. All registers hold while the pipeline is stalled.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K = 0,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  shift_mode_t      mode_i,
`ifdef SHIFTER_FLAGS_EN
  output logic [WIDTH-1:0] data_d_o,
`endif
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output shift_mode_t      mode_o
);

  localparam int S = 1 << K;

  logic             vld_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [SHW-1:0]   amt_q;
  shift_mode_t      mode_q;

  // SRA re-reads the MSB of this stage's own input, so sign survives every stage.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input shift_mode_t m);
    case (m)
      SH_SLL:  return {d[WIDTH-S-1:0], {S{1'b0}}};
      SH_SRA:  return {{S{d[WIDTH-1]}}, d[WIDTH-1:S]};
      SH_SRL:  return {{S{1'b0}}, d[WIDTH-1:S]};
      default: return {d[S-1:0], d[WIDTH-1:S]};
    endcase
  endfunction

  always_comb begin
    data_d = data_i;
    if (amt_i[K]) data_d = shift_step(data_i, mode_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      amt_q  <= '0;
      mode_q <= SH_SLL;
    end else if (!stall_i) begin
      vld_q  <= vld_i;
      data_q <= data_d;
      amt_q  <= amt_i;
      mode_q <= mode_i;
    end
  end

`ifdef SHIFTER_FLAGS_EN
  assign data_d_o = data_d;
`endif
  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign amt_o  = amt_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRA/ROR/SRL shifter, one registered stage per shift-amount bit,
// valid/ready on both sides. Define SHIFTER_FLAGS_EN to add registered out_z/out_n.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH),
  localparam int STAGES = SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFTER_FLAGS_EN
  output logic             out_z,
  output logic             out_n,
`endif
  output logic [WIDTH-1:0] out_data
);

  if (WIDTH < MIN_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("pipelined_shifter: WIDTH must be a power of two and at least %0d", MIN_WIDTH);
  end

  logic             stall;
  logic             vld_in  [STAGES];
  logic [WIDTH-1:0] data_in [STAGES];
  logic [SHW-1:0]   amt_in  [STAGES];
  shift_mode_t      mode_in [STAGES];
  logic             vld_q   [STAGES];
  logic [WIDTH-1:0] data_q  [STAGES];
  logic [SHW-1:0]   amt_q   [STAGES];
  shift_mode_t      mode_q  [STAGES];
`ifdef SHIFTER_FLAGS_EN
  logic [WIDTH-1:0] nxt_d   [STAGES];
`endif

  // A held output freezes the whole pipeline, bubbles included.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_in[k]  = in_valid & in_ready;
      assign data_in[k] = in_data;
      assign amt_in[k]  = in_amt;
      assign mode_in[k] = shift_mode_t'(in_mode);
    end else begin : g_link
      assign vld_in[k]  = vld_q[k-1];
      assign data_in[k] = data_q[k-1];
      assign amt_in[k]  = amt_q[k-1];
      assign mode_in[k] = mode_q[k-1];
    end

    shifter_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .stall_i  (stall),
      .vld_i    (vld_in[k]),
      .data_i   (data_in[k]),
      .amt_i    (amt_in[k]),
      .mode_i   (mode_in[k]),
`ifdef SHIFTER_FLAGS_EN
      .data_d_o (nxt_d[k]),
`endif
      .vld_o    (vld_q[k]),
      .data_o   (data_q[k]),
      .amt_o    (amt_q[k]),
      .mode_o   (mode_q[k])
    );
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

`ifdef SHIFTER_FLAGS_EN
  logic z_q, z_d;
  logic n_q, n_d;

  // Flags come from the final stage's next value so they register with out_data.
  assign z_d = (nxt_d[STAGES-1] == '0);
  assign n_d = nxt_d[STAGES-1][WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (!stall) begin
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign out_z = z_q;
  assign out_n = n_q;
`endif

endmodule
